// File: rtl/param_load_sequencer_pkg.sv
// Shared constants, state encoding and status layout
// for the synthesizer parameter bank loader.
package param_load_sequencer_pkg;

  localparam int NUM_VOICES = 64;
  localparam int WORD_W     = 16;
  localparam int PTR_W      = $clog2(NUM_VOICES);
  localparam int BANK_W     = NUM_VOICES * WORD_W;
  localparam int STATUS_W   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  localparam int ST_AMP_FULL   = 0;
  localparam int ST_OFF_FULL   = 1;
  localparam int ST_PW_FULL    = 2;
  localparam int ST_OVERFLOW   = 3;
  localparam int ST_COMMIT_ERR = 4;
  localparam int ST_STATE      = 5;

endpackage

// File: rtl/param_load_sequencer_bank.sv
// One parameter stream: shadow array, write pointer,
// full flag and the active copy taken on commit.
module param_bank
  import param_load_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [WORD_W-1:0] data,
  input  logic              clear,
  input  logic              commit_en,
  output logic [BANK_W-1:0] active,
  output logic              full,
  output logic              ovf
);

  logic [WORD_W-1:0] shadow [NUM_VOICES];
  logic [PTR_W-1:0]  ptr;
  logic              accept;

  assign accept = wr && !full && !commit_en && !clear;
  assign ovf    = wr && (full || commit_en);

  // Shadow storage; contents survive abort and commit.
  always_ff @(posedge clk) begin
    if (accept) begin
      shadow[ptr] <= data;
    end
  end

  // Write pointer saturates at the last voice once full.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr  <= '0;
      full <= 1'b0;
    end else if (clear || commit_en) begin
      ptr  <= '0;
      full <= 1'b0;
    end else if (accept) begin
      if (ptr == PTR_W'(NUM_VOICES - 1)) begin
        full <= 1'b1;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

  // Publish the whole shadow in the commit cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active <= '0;
    end else if (commit_en) begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        active[k*WORD_W +: WORD_W] <= shadow[k];
      end
    end
  end

endmodule

// File: rtl/param_load_sequencer.sv
// Load/commit controller for the amplitude, offset
// and phase-word banks of the synthesizer array.
module param_load_sequencer
  import param_load_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                amp_write,
  input  logic [WORD_W-1:0]   amp_data,
  input  logic                off_write,
  input  logic [WORD_W-1:0]   off_data,
  input  logic                pw_write,
  input  logic [WORD_W-1:0]   pw_data,
  input  logic                commit_req,
  input  logic                abort,
  output logic [BANK_W-1:0]   active_amps,
  output logic [BANK_W-1:0]   active_offsets,
  output logic [BANK_W-1:0]   active_phasewords,
  output logic                phase_reset,
  output logic [STATUS_W-1:0] status
);

  state_t     state, state_n;
  logic       commit_en;
  logic       clear;
  logic       cerr_set;
  logic       any_wr;
  logic       overflow;
  logic       commit_err;
  logic [2:0] full;
  logic [2:0] ovf;

  assign commit_en = (state == COMMIT);
  assign any_wr    = amp_write || off_write || pw_write;

  param_bank u_amp (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (amp_write),
    .data      (amp_data),
    .clear     (clear),
    .commit_en (commit_en),
    .active    (active_amps),
    .full      (full[0]),
    .ovf       (ovf[0])
  );

  param_bank u_off (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (off_write),
    .data      (off_data),
    .clear     (clear),
    .commit_en (commit_en),
    .active    (active_offsets),
    .full      (full[1]),
    .ovf       (ovf[1])
  );

  param_bank u_pw (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (pw_write),
    .data      (pw_data),
    .clear     (clear),
    .commit_en (commit_en),
    .active    (active_phasewords),
    .full      (full[2]),
    .ovf       (ovf[2])
  );

  // Next state, abort clearing and commit error detect.
  always_comb begin
    state_n  = state;
    clear    = 1'b0;
    cerr_set = 1'b0;
    unique case (state)
      IDLE: begin
        cerr_set = commit_req && !abort;
        if (any_wr) state_n = LOADING;
      end
      LOADING: begin
        if (abort) begin
          clear   = 1'b1;
          state_n = IDLE;
        end else begin
          cerr_set = commit_req;
          if (&full) state_n = READY;
        end
      end
      READY: begin
        if (abort) begin
          clear   = 1'b1;
          state_n = IDLE;
        end else if (commit_req) begin
          state_n = COMMIT;
        end
      end
      COMMIT: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, phase reset pulse and sticky flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      phase_reset <= 1'b0;
      overflow    <= 1'b0;
      commit_err  <= 1'b0;
    end else begin
      state       <= state_n;
      phase_reset <= (state_n == COMMIT);
      overflow    <= (overflow && !commit_en) || (|ovf);
      commit_err  <= !commit_en && (commit_err || cerr_set);
    end
  end

  // Status word packing from registered state.
  always_comb begin
    status                      = '0;
    status[ST_AMP_FULL]         = full[0];
    status[ST_OFF_FULL]         = full[1];
    status[ST_PW_FULL]          = full[2];
    status[ST_OVERFLOW]         = overflow;
    status[ST_COMMIT_ERR]       = commit_err;
    status[ST_STATE +: 2]       = state;
  end

endmodule

// File: tb/tb_param_load_sequencer.sv
// Randomized scoreboard bench for the parameter
// bank load/commit controller.
module tb_param_load_sequencer;
  import param_load_sequencer_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              amp_write = 1'b0;
  logic [WORD_W-1:0] amp_data = '0;
  logic              off_write = 1'b0;
  logic [WORD_W-1:0] off_data = '0;
  logic              pw_write = 1'b0;
  logic [WORD_W-1:0] pw_data = '0;
  logic              commit_req = 1'b0;
  logic              abort = 1'b0;
  logic [BANK_W-1:0] active_amps;
  logic [BANK_W-1:0] active_offsets;
  logic [BANK_W-1:0] active_phasewords;
  logic              phase_reset;
  logic [15:0]       status;

  always #5 clk = ~clk;

  param_load_sequencer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .amp_write         (amp_write),
    .amp_data          (amp_data),
    .off_write         (off_write),
    .off_data          (off_data),
    .pw_write          (pw_write),
    .pw_data           (pw_data),
    .commit_req        (commit_req),
    .abort             (abort),
    .active_amps       (active_amps),
    .active_offsets    (active_offsets),
    .active_phasewords (active_phasewords),
    .phase_reset       (phase_reset),
    .status            (status)
  );

  typedef struct packed {
    logic [BANK_W-1:0] a;
    logic [BANK_W-1:0] o;
    logic [BANK_W-1:0] p;
  } bank_t;

  bank_t       sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cnt[3];
  logic [15:0] sh_m[3][NUM_VOICES];
  bit          ovf_m;
  bit          cerr_m;
  bit          mon_en = 1'b0;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  task automatic check_bank(string name,
                            logic [BANK_W-1:0] act,
                            logic [BANK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int k = 0; k < NUM_VOICES; k++) begin
        if (act[k*WORD_W +: WORD_W] !==
            exp[k*WORD_W +: WORD_W]) begin
          $display("FAIL %s voice=%0d actual=%h required=%h",
                   name, k, act[k*WORD_W +: WORD_W],
                   exp[k*WORD_W +: WORD_W]);
          break;
        end
      end
    end
  endtask

  function automatic logic [BANK_W-1:0] pack(int s);
    logic [BANK_W-1:0] v;
    for (int k = 0; k < NUM_VOICES; k++)
      v[k*WORD_W +: WORD_W] = sh_m[s][k];
    return v;
  endfunction

  function automatic bit all_full_m();
    return cnt[0] == NUM_VOICES && cnt[1] == NUM_VOICES &&
           cnt[2] == NUM_VOICES;
  endfunction

  function automatic logic [15:0] exp_status();
    logic [15:0] r;
    r = '0;
    if (cnt[0] + cnt[1] + cnt[2] == 0) r[6:5] = 2'd0;
    else if (all_full_m()) r[6:5] = 2'd2;
    else r[6:5] = 2'd1;
    r[4] = cerr_m;
    r[3] = ovf_m;
    r[2] = (cnt[2] == NUM_VOICES);
    r[1] = (cnt[1] == NUM_VOICES);
    r[0] = (cnt[0] == NUM_VOICES);
    return r;
  endfunction

  function automatic logic [15:0] pat(int s, int i);
    if (i >= NUM_VOICES) return 16'hBEEF;
    return 16'(s * 16'h1000 + i);
  endfunction

  task automatic model_reset();
    cnt = '{0, 0, 0};
    ovf_m = 1'b0;
    cerr_m = 1'b0;
  endtask

  task automatic model_wr(int s, logic [15:0] d);
    if (cnt[s] >= NUM_VOICES) ovf_m = 1'b1;
    else begin
      sh_m[s][cnt[s]] = d;
      cnt[s]++;
    end
  endtask

  task automatic settle();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic load(int na, int no, int np, bit patm);
    int rem[3];
    int idx[3];
    bit w[3];
    logic [15:0] d[3];
    rem = '{na, no, np};
    idx = '{0, 0, 0};
    while (rem[0] + rem[1] + rem[2] > 0) begin
      for (int s = 0; s < 3; s++) begin
        w[s] = (rem[s] > 0) && ($urandom_range(0, 3) != 0);
        d[s] = patm ? pat(s, idx[s]) : 16'($urandom);
        if (w[s]) begin
          model_wr(s, d[s]);
          rem[s]--;
          idx[s]++;
        end
      end
      amp_write = w[0]; amp_data = d[0];
      off_write = w[1]; off_data = d[1];
      pw_write  = w[2]; pw_data  = d[2];
      @(posedge clk); #1;
      amp_write = 1'b0;
      off_write = 1'b0;
      pw_write  = 1'b0;
    end
  endtask

  task automatic commit(bit wr_in_commit);
    bank_t e;
    bit ok;
    ok = all_full_m();
    commit_req = 1'b1;
    @(posedge clk); #1;
    commit_req = 1'b0;
    if (ok) begin
      e.a = pack(0);
      e.o = pack(1);
      e.p = pack(2);
      sb.push_back(e);
      cnt = '{0, 0, 0};
      cerr_m = 1'b0;
      ovf_m = 1'b0;
      if (wr_in_commit) begin
        pw_write = 1'b1;
        pw_data = 16'($urandom);
        ovf_m = 1'b1;
      end
      check("phase_reset_in_commit", 32'(phase_reset), 1);
      @(posedge clk); #1;
      pw_write = 1'b0;
    end else begin
      cerr_m = 1'b1;
    end
    settle();
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    cnt = '{0, 0, 0};
    settle();
  endtask

  task automatic full_load_random();
    load(NUM_VOICES, NUM_VOICES, NUM_VOICES, 1'b0);
    settle();
    check("status_ready", 32'(status), 32'(exp_status()));
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_status"}, 32'(status), 0);
    check({tag, "_phase_reset"}, 32'(phase_reset), 0);
    check_bank({tag, "_amps"}, active_amps, '0);
    check_bank({tag, "_offsets"}, active_offsets, '0);
    check_bank({tag, "_pw"}, active_phasewords, '0);
  endtask

  initial begin : monitor
    bank_t cur;
    cur = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      check_bank("mon_amps", active_amps, cur.a);
      check_bank("mon_offsets", active_offsets, cur.o);
      check_bank("mon_pw", active_phasewords, cur.p);
      if (!reset_n) begin
        cur = '0;
      end else if (phase_reset !== 1'b0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL phase_reset_unexpected actual=%b required=0",
                   phase_reset);
        end else begin
          cur = sb.pop_front();
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r;
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < NUM_VOICES; k++) sh_m[s][k] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_reset_state("reset");
    mon_en = 1'b1;

    load(NUM_VOICES, NUM_VOICES, NUM_VOICES, 1'b1);
    settle();
    check("full_status", 32'(status), 32'h0047);
    commit(1'b0);
    check("full_idle", 32'(status), 0);
    check("full_amp_v5", 32'(active_amps[5*16 +: 16]), 5);
    check("full_off_v5", 32'(active_offsets[5*16 +: 16]),
          32'h1005);

    load(10, 0, 0, 1'b0);
    settle();
    commit(1'b0);
    check("early_status", 32'(status), 32'h0030);
    do_abort();
    check("early_abort", 32'(status), 32'(exp_status()));

    load(NUM_VOICES + 1, 0, 0, 1'b1);
    settle();
    check("ovf_status", 32'(status), 32'(exp_status()));
    check("ovf_bits", 32'(status[3] & status[0]), 1);
    load(0, NUM_VOICES, NUM_VOICES, 1'b1);
    settle();
    check("ovf_ready", 32'(status), 32'(exp_status()));
    commit(1'b0);
    check("ovf_v63", 32'(active_amps[63*16 +: 16]), 32'h003F);
    check("ovf_cleared", 32'(status), 0);

    full_load_random();
    commit(1'b0);
    load(30, 30, 30, 1'b0);
    settle();
    check("abort_loading", 32'(status), 32'(exp_status()));
    do_abort();
    check("abort_idle", 32'(status), 32'(exp_status()));
    full_load_random();
    commit(1'b0);

    full_load_random();
    abort = 1'b1;
    commit_req = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    commit_req = 1'b0;
    cnt = '{0, 0, 0};
    settle();
    check("abort_commit", 32'(status), 32'(exp_status()));

    full_load_random();
    commit(1'b1);
    check("wr_in_commit", 32'(status), 32'(exp_status()));

    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(0, 2);
      if (r == 0) begin
        load(NUM_VOICES, NUM_VOICES,
             NUM_VOICES + $urandom_range(0, 2), 1'b0);
        settle();
        check("rnd_ready", 32'(status), 32'(exp_status()));
        commit(1'($urandom_range(0, 1)));
      end else if (r == 1) begin
        load($urandom_range(1, 63), $urandom_range(0, 63),
             $urandom_range(0, 63), 1'b0);
        settle();
        check("rnd_partial", 32'(status), 32'(exp_status()));
        do_abort();
      end else begin
        load($urandom_range(1, 40), 0,
             $urandom_range(0, 40), 1'b0);
        settle();
        commit(1'b0);
        check("rnd_early", 32'(status), 32'(exp_status()));
        do_abort();
      end
      check("rnd_end", 32'(status), 32'(exp_status()));
    end

    full_load_random();
    commit(1'b0);
    load(20, 5, 0, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    check_reset_state("rst_loading");

    full_load_random();
    commit_req = 1'b1;
    @(posedge clk); #1;
    commit_req = 1'b0;
    check("rst_commit_pulse", 32'(phase_reset), 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    model_reset();
    check_reset_state("rst_commit");

    full_load_random();
    commit(1'b0);
    settle();
    check("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/param_load_sequencer.md
# param_load_sequencer

Double-buffered loader and commit controller for the 64-voice synthesizer parameter banks. Accepts three 16-bit pipe streams (amplitude, offset, phase word) and fills a shadow bank per stream at the voice index given by a per-stream write pointer. On an explicit commit, once all three shadows hold 64 words, it copies all three shadows into the active banks atomically and pulses a phase reset to the synthesizer array. It sits between the host pipe endpoints and the synthesizer array, replacing free-running block counters and reset-triggered copy.

## Interface
- NUM_VOICES, 64: voices per bank; pointer width is log2(NUM_VOICES).
- WORD_W, 16: bits per parameter word.

- clk  in  1  single clock for all logic (host interface clock)
- reset_n  in  1  synchronous, active-low reset
- amp_write  in  1  amplitude word strobe
- amp_data  in  WORD_W  amplitude word
- off_write  in  1  offset word strobe
- off_data  in  WORD_W  offset word
- pw_write  in  1  phase-word strobe
- pw_data  in  WORD_W  phase word
- commit_req  in  1  single-cycle request to publish shadows
- abort  in  1  single-cycle request to discard the partial load
- active_amps, active_offsets, active_phasewords  out  NUM_VOICES*WORD_W each  active banks; voice k at bits [k*WORD_W +: WORD_W]
- phase_reset  out  1  one-cycle pulse to the synthesizer array when the active banks change
- status  out  16  {9'b0, state[1:0], commit_err, overflow, pw_full, off_full, amp_full}

## Operation
- FSM states: IDLE (all pointers 0), LOADING (at least one word accepted), READY (all three streams full), COMMIT (one-cycle copy).
- A write on any stream writes its shadow at its pointer, then increments the pointer. The first write in IDLE moves the FSM to LOADING.
- A stream is full after its 64th word. Further writes to a full stream are dropped and set the sticky overflow flag. The pointer saturates and does not wrap.
- Enter READY in the cycle after all three full flags are set.
- In READY, commit_req moves the FSM to COMMIT. In COMMIT, active <= shadow for all three banks, phase_reset = 1, all pointers and full flags clear, and the FSM then returns to IDLE.
- commit_req in IDLE or LOADING is ignored and sets the sticky commit_err flag.
- Writes in the COMMIT cycle are dropped and set overflow.
- abort in LOADING or READY clears the pointers and full flags and returns to IDLE. The active banks are unchanged. abort in IDLE or COMMIT has no effect.
- If abort and commit_req are asserted in the same cycle, abort wins.
- The sticky flags (overflow, commit_err) clear only on reset_n or on the commit cycle.
- Shadow contents are not cleared by abort or commit. Words not rewritten keep their previous values, but commit requires all three streams to be full anyway.

## Timing
- Reset (reset_n = 0 at a clock edge): state IDLE, pointers 0, all flags 0, active banks all zero, phase_reset 0, status 0. Shadow contents are don't-care.
- Write strobed at edge t: the word is in the shadow and the pointer is incremented after edge t. Status full bits reflect the write from t+1.
- commit_req at edge t in READY: COMMIT during cycle t+1, with phase_reset high in that cycle only. Active banks show the new values after edge t+1. The FSM is IDLE from t+2.
- All outputs are registered. There is no combinational path from the inputs to the outputs.
- reset_n low in any state, including COMMIT, aborts immediately. If reset lands on the COMMIT edge, the active banks take reset values.

## Structure
- Shared package: NUM_VOICES, WORD_W, pointer width, the state enum (IDLE = 0, LOADING = 1, READY = 2, COMMIT = 3), and the status bit positions.
- One sub-module, param_bank, instantiated three times. Each instance holds the shadow register array, the write pointer, the full flag, the overflow strobe, and the active copy on commit_en.
- The top level holds the FSM, the sticky flags and status packing.

## Test plan
- **Full load and commit:** write words 0x0000..0x003F to amp, 0x1000+k to offset and 0x2000+k to pw, then pulse commit_req.
  - status goes to READY (state = 2, full bits = 111).
  - phase_reset is high for exactly one cycle.
  - active_amps[k*16 +: 16] = k and active_offsets[...] = 0x1000+k.
  - state returns to 0.
- **Early commit:** 10 amp words only, then commit_req.
  - Active banks stay 0, commit_err = 1, state stays LOADING, no phase_reset.
- **Overflow:** 65 amp writes, with the 65th data = 0xBEEF.
  - overflow = 1 and amp_full = 1.
  - After completing the other streams and committing, voice 63 holds word 63 and 0xBEEF is absent.
- **Abort:** after a committed load A, partially load B (30 words each), then abort, then fully load C and commit.
  - Active banks = A until C's commit cycle, then = C.
  - Pointers restarted at 0 after the abort.
- **Simultaneous abort + commit_req in READY:** state goes to IDLE, active banks unchanged, no phase_reset.
- **Reset mid-operation:** reset_n = 0 in LOADING and separately in the COMMIT cycle.
  - The next cycle shows status = 0, active banks all zero, phase_reset = 0.
